strb_split_ctrl: RTL and testbench

//  Converts AXI write strobes into a sequence of naturally aligned, power-of-two byte requests, each

---
 rtl/strb_split_pkg.sv | 11 +
 rtl/strb_split_ctrl_if.sv | 22 ++
 rtl/strb_chunk_pick.sv | 35 +++
 rtl/strb_split_ctrl.sv | 72 +++++++
 tb/tb_strb_split_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/strb_split_pkg.sv
// strb_split_pkg: FSM state and request size encodings shared by the strobe splitter.
package strb_split_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [2:0] SZ_1B  = 3'd0;
   localparam logic [2:0] SZ_2B  = 3'd1;
   localparam logic [2:0] SZ_4B  = 3'd2;
   localparam logic [2:0] SZ_8B  = 3'd3;
   localparam logic [2:0] SZ_16B = 3'd4;
   localparam logic [2:0] SZ_32B = 3'd5;
   localparam logic [2:0] SZ_64B = 3'd6;
endpackage

// File: rtl/strb_split_ctrl_if.sv
// strb_split_ctrl_if: strobe-beat input and split-request output handshakes.
interface strb_split_ctrl_if
   import strb_split_pkg::*;
#(parameter int STRB_W = 8);
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int SIZE_W = $clog2($clog2(STRB_W) + 1);
   logic              s_valid;
   logic              s_ready;
   logic [STRB_W-1:0] s_strb;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [SIZE_W-1:0] m_size;
   logic [OFF_W-1:0]  m_offset;
   logic [STRB_W-1:0] m_mask;
   logic              m_chunk_last;
   logic              m_beat_last;
   modport master (output s_valid, s_strb, s_last, m_ready,
                   input  s_ready, m_valid, m_size, m_offset, m_mask, m_chunk_last, m_beat_last);
   modport slave  (input  s_valid, s_strb, s_last, m_ready,
                   output s_ready, m_valid, m_size, m_offset, m_mask, m_chunk_last, m_beat_last);
endinterface

// File: rtl/strb_chunk_pick.sv
// strb_chunk_pick: picks the largest aligned power-of-two run starting at the lowest set residual byte.
module strb_chunk_pick
   import strb_split_pkg::*;
#(
   parameter int STRB_W    = 8,
   parameter int MAX_BYTES = STRB_W,
   parameter int OFF_W     = $clog2(STRB_W),
   parameter int SIZE_W    = $clog2($clog2(STRB_W) + 1)
) (
   input  logic [STRB_W-1:0] i_res,
   output logic [OFF_W-1:0]  o_off,
   output logic [SIZE_W-1:0] o_size,
   output logic [STRB_W-1:0] o_mask,
   output logic              o_last
);
   localparam int MAXK = $clog2(MAX_BYTES);
   int                w_o;
   int                w_k;
   logic [STRB_W-1:0] w_lm;
   always_comb begin
      w_o  = 0;
      w_k  = 0;
      w_lm = '0;
      for (int b = STRB_W - 1; b >= 0; b--) if (i_res[b]) w_o = b;
      // alignment and fullness only shrink as k grows, so stop at the first failing size
      for (int j = 1; j <= MAXK; j++) begin
         w_lm = {STRB_W{1'b1}} >> (STRB_W - (1 << j));
         if (w_k == j - 1 && w_o % (1 << j) == 0 && ((i_res >> w_o) & w_lm) == w_lm) w_k = j;
      end
      o_off  = OFF_W'(w_o);
      o_size = SIZE_W'(w_k);
      o_mask = ({STRB_W{1'b1}} >> (STRB_W - (1 << w_k))) << w_o;
      o_last = i_res == o_mask;
   end
endmodule

// File: rtl/strb_split_ctrl.sv
// strb_split_ctrl: splits AXI write strobes into aligned power-of-two byte requests.
// Defining STRB_SPLIT_PERF_EN adds the perf_beats/perf_reqs handshake counters.
module strb_split_ctrl
   import strb_split_pkg::*;
#(
   parameter int STRB_W    = 8,
   parameter int MAX_BYTES = STRB_W
) (
   input  logic               clk,
   input  logic               rst,
`ifdef STRB_SPLIT_PERF_EN
   output logic [31:0]        perf_beats,
   output logic [31:0]        perf_reqs,
`endif
   strb_split_ctrl_if.slave   io_bus
);
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int SIZE_W = $clog2($clog2(STRB_W) + 1);
   state_t            r_state;
   logic [STRB_W-1:0] r_res;
   logic              r_last;
   logic [OFF_W-1:0]  w_off;
   logic [SIZE_W-1:0] w_size;
   logic [STRB_W-1:0] w_mask;
   logic              w_clast;
   logic              w_busy;
   logic              w_s_hs;
   logic              w_m_hs;
   strb_chunk_pick #(.STRB_W(STRB_W), .MAX_BYTES(MAX_BYTES)) u_pick (
      .i_res  (r_res),
      .o_off  (w_off),
      .o_size (w_size),
      .o_mask (w_mask),
      .o_last (w_clast)
   );
   assign w_busy              = r_state == BUSY;
   assign w_s_hs              = io_bus.s_valid && io_bus.s_ready;
   assign w_m_hs              = w_busy && io_bus.m_ready;
   // taking the next beat alongside the last chunk keeps single-request beats at full rate
   assign io_bus.s_ready      = !rst && (!w_busy || (io_bus.m_ready && w_clast));
   assign io_bus.m_valid      = w_busy;
   assign io_bus.m_offset     = w_busy ? w_off : '0;
   assign io_bus.m_size       = w_busy ? w_size : '0;
   assign io_bus.m_mask       = w_busy ? w_mask : '0;
   assign io_bus.m_chunk_last = w_busy && w_clast;
   assign io_bus.m_beat_last  = w_busy && w_clast && r_last;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_res   <= '0;
         r_last  <= 1'b0;
      end else if (w_s_hs && io_bus.s_strb != '0) begin
         r_state <= BUSY;
         r_res   <= io_bus.s_strb;
         r_last  <= io_bus.s_last;
      end else if (w_m_hs) begin
         r_res   <= r_res & ~w_mask;
         r_state <= w_clast ? IDLE : BUSY;
      end
   end
`ifdef STRB_SPLIT_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_beats <= '0;
         perf_reqs  <= '0;
      end else begin
         perf_beats <= perf_beats + 32'(w_s_hs);
         perf_reqs  <= perf_reqs + 32'(w_m_hs);
      end
   end
`endif
endmodule

// File: tb/tb_strb_split_ctrl.sv
// tb_strb_split_ctrl: directed and random checks of strb_split_ctrl at MAX_BYTES=8 and MAX_BYTES=2.
module tb_strb_split_ctrl;
   import strb_split_pkg::*;
   typedef struct {int off; int size; int mask; bit cl; bit bl;} req_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   req_t q8[$], q2[$], tmp[$];
   req_t e8, e2;
   logic [15:0] obs8, obs2, prev8, prev2;
   bit stall8, stall2;
   int beats8, reqs8, beats2, reqs2;
   logic [31:0] pb8, pr8, pb2, pr2;
   always #5 clk = ~clk;
   strb_split_ctrl_if #(.STRB_W(8)) a ();
   strb_split_ctrl_if #(.STRB_W(8)) b ();
   assign b.s_valid = a.s_valid;
   assign b.s_strb  = a.s_strb;
   assign b.s_last  = a.s_last;
   assign b.m_ready = a.m_ready;
   assign obs8 = {a.m_valid, a.m_offset, a.m_size, a.m_mask, a.m_chunk_last, a.m_beat_last};
   assign obs2 = {b.m_valid, b.m_offset, b.m_size, b.m_mask, b.m_chunk_last, b.m_beat_last};
   strb_split_ctrl #(.STRB_W(8), .MAX_BYTES(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
`ifdef STRB_SPLIT_PERF_EN
      .perf_beats (pb8),
      .perf_reqs  (pr8),
`endif
      .io_bus     (a.slave)
   );
   strb_split_ctrl #(.STRB_W(8), .MAX_BYTES(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
`ifdef STRB_SPLIT_PERF_EN
      .perf_beats (pb2),
      .perf_reqs  (pr2),
`endif
      .io_bus     (b.slave)
   );
`ifndef STRB_SPLIT_PERF_EN
   assign {pb8, pr8, pb2, pr2} = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rq(input int off, input int size, input int mask, input bit cl, input bit bl);
      return {1'b1, 3'(off), 2'(size), 8'(mask), cl, bl};
   endfunction

   // reference: peel the lowest set byte, halve the chunk from the cap until aligned and fully strobed
   function automatic void build(input logic [7:0] strb, input bit last, input int maxb);
      int r, o, n, m;
      tmp.delete();
      r = int'(strb);
      while (r != 0) begin
         o = 0;
         while (((r >> o) & 1) == 0) o++;
         n = maxb;
         while (n > 1 && (o % n != 0 || ((r >> o) & ((1 << n) - 1)) != (1 << n) - 1)) n = n / 2;
         m = ((1 << n) - 1) << o;
         r = r & ~m;
         tmp.push_back('{o, $clog2(n), m, r == 0, last && r == 0});
      end
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         stall8 = 1'b0;
         beats8 = 0;
         reqs8 = 0;
      end else begin
         if (stall8) chk("hold8", obs8, prev8);
         if (a.m_valid && a.m_ready) begin
            if (q8.size() == 0) chk("extra8", obs8, 0);
            else begin
               e8 = q8.pop_front();
               chk("req8", obs8, rq(e8.off, e8.size, e8.mask, e8.cl, e8.bl));
            end
            reqs8++;
         end
         stall8 = a.m_valid && !a.m_ready;
         prev8 = obs8;
         if (a.s_valid && a.s_ready) begin
            build(a.s_strb, a.s_last, 8);
            foreach (tmp[i]) q8.push_back(tmp[i]);
            beats8++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q2.delete();
         stall2 = 1'b0;
         beats2 = 0;
         reqs2 = 0;
      end else begin
         if (stall2) chk("hold2", obs2, prev2);
         if (b.m_valid && b.m_ready) begin
            if (q2.size() == 0) chk("extra2", obs2, 0);
            else begin
               e2 = q2.pop_front();
               chk("req2", obs2, rq(e2.off, e2.size, e2.mask, e2.cl, e2.bl));
            end
            reqs2++;
         end
         stall2 = b.m_valid && !b.m_ready;
         prev2 = obs2;
         if (b.s_valid && b.s_ready) begin
            build(b.s_strb, b.s_last, 2);
            foreach (tmp[i]) q2.push_back(tmp[i]);
            beats2++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] s, input bit l);
      a.s_valid = v;
      a.s_strb  = s;
      a.s_last  = l;
   endtask

   initial begin
      drive(0, 8'h00, 0);
      a.m_ready = 1'b1;
      #12;
      chk("rst_srdy", a.s_ready, 0);
      chk("rst_out", obs8, 0);
      tick();
      rst = 1'b0;
      // full beat, single 8-byte request
      drive(1, 8'hFF, 1);
      #2 chk("t1_srdy", a.s_ready, 1);
      tick();
      drive(0, 8'h00, 0);
      #2 chk("t1_req", obs8, rq(0, 3, 8'hFF, 1, 1));
      tick();
      #2 chk("t1_idle", obs8, 0);
      // four-way split
      drive(1, 8'h7E, 0);
      tick();
      drive(0, 8'h00, 0);
      #2 chk("t2_r0", obs8, rq(1, 0, 8'h02, 0, 0));
      tick();
      #2 chk("t2_r1", obs8, rq(2, 1, 8'h0C, 0, 0));
      tick();
      #2 chk("t2_r2", obs8, rq(4, 1, 8'h30, 0, 0));
      tick();
      #2 chk("t2_r3", obs8, rq(6, 0, 8'h40, 1, 0));
      tick();
      #2 chk("t2_idle", obs8, 0);
      repeat (6) tick();
      // size cap of 2 bytes
      drive(1, 8'hF0, 0);
      tick();
      drive(0, 8'h00, 0);
      #2 chk("t3_r0", obs2, rq(4, 1, 8'h30, 0, 0));
      chk("t3_srdy0", b.s_ready, 0);
      tick();
      #2 chk("t3_r1", obs2, rq(6, 1, 8'hC0, 1, 0));
      chk("t3_srdy1", b.s_ready, 1);
      tick();
      #2 chk("t3_idle", obs2, 0);
      repeat (4) tick();
      // back-to-back single-request beats including a zero beat
      drive(1, 8'h0F, 0);
      #2 chk("t4_srdy0", a.s_ready, 1);
      tick();
      drive(1, 8'hF0, 0);
      #2 chk("t4_srdy1", a.s_ready, 1);
      chk("t4_r0", obs8, rq(0, 2, 8'h0F, 1, 0));
      tick();
      drive(1, 8'h00, 0);
      #2 chk("t4_srdy2", a.s_ready, 1);
      chk("t4_r1", obs8, rq(4, 2, 8'hF0, 1, 0));
      tick();
      drive(1, 8'h01, 0);
      #2 chk("t4_srdy3", a.s_ready, 1);
      chk("t4_zero", obs8, 0);
      tick();
      drive(0, 8'h00, 0);
      #2 chk("t4_r2", obs8, rq(0, 0, 8'h01, 1, 0));
      repeat (8) tick();
      // back-pressure on the first request
      drive(1, 8'h36, 0);
      a.m_ready = 1'b0;
      tick();
      drive(0, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         #2 chk("t5_stall", obs8, rq(1, 0, 8'h02, 0, 0));
         chk("t5_srdy", a.s_ready, 0);
         tick();
      end
      a.m_ready = 1'b1;
      #2 chk("t5_r0", obs8, rq(1, 0, 8'h02, 0, 0));
      tick();
      #2 chk("t5_r1", obs8, rq(2, 0, 8'h04, 0, 0));
      tick();
      #2 chk("t5_r2", obs8, rq(4, 1, 8'h30, 1, 0));
      repeat (8) tick();
      // async reset in the middle of a beat
      drive(1, 8'h7E, 0);
      tick();
      drive(0, 8'h00, 0);
      #2 chk("t6_r0", obs8, rq(1, 0, 8'h02, 0, 0));
      tick();
      rst = 1'b1;
      drive(1, 8'hFF, 1);
      #1 chk("t6_rst_out", obs8, 0);
      chk("t6_rst_srdy", a.s_ready, 0);
`ifdef STRB_SPLIT_PERF_EN
      chk("t6_pb", pb8, 0);
      chk("t6_pr", pr8, 0);
`endif
      tick();
      #2 chk("t6_rst_srdy2", a.s_ready, 0);
      tick();
      rst = 1'b0;
      drive(0, 8'h00, 0);
      #2 chk("t6_srdy", a.s_ready, 1);
      chk("t6_idle", obs8, 0);
      tick();
      #2 chk("t6_idle2", obs8, 0);
      // random traffic against the reference queues
      for (int i = 0; i < 400; i++) begin
         int c;
         c = int'($urandom_range(0, 7));
         drive($urandom_range(0, 9) < 7, c == 0 ? 8'h00 : c == 1 ? 8'hFF : 8'($urandom), 1'($urandom));
         a.m_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      drive(0, 8'h00, 0);
      a.m_ready = 1'b1;
      repeat (20) tick();
      chk("drain8", q8.size(), 0);
      chk("drain2", q2.size(), 0);
`ifdef STRB_SPLIT_PERF_EN
      chk("perf_beats8", pb8, beats8);
      chk("perf_reqs8", pr8, reqs8);
      chk("perf_beats2", pb2, beats2);
      chk("perf_reqs2", pr2, reqs2);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
